// File: rtl/sync_array.sv
// Multi-channel control-signal synchroniser with an optional stability filter,
// per-channel edge-detect pulses and sticky, clearable event flags.
module sync_array #(
    parameter int                  CHANNELS   = 8,
    parameter int                  STAGES     = 2,
    parameter int                  FILTER_CYC = 0,
    parameter logic [CHANNELS-1:0] RESET_VAL  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS-1:0]   i_ctrl,
    input  logic [2*CHANNELS-1:0] i_mode,
    input  logic [CHANNELS-1:0]   i_clear,
    output logic [CHANNELS-1:0]   o_level,
    output logic [CHANNELS-1:0]   o_pulse,
    output logic [CHANNELS-1:0]   o_event
);

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_array: STAGES must be >= 2");
    end

    logic [CHANNELS-1:0] sync_r [STAGES];
    logic [CHANNELS-1:0] sync_out;
    logic [CHANNELS-1:0] prev_r;
    logic [CHANNELS-1:0] event_r;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;

    // Bare flop chain: any logic between stages would defeat metastability settling.
    // NOTE: sequential state uses <= so every stage samples its predecessor's old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < STAGES; n++) sync_r[n] <= RESET_VAL;
        end else begin
            sync_r[0] <= i_ctrl;
            for (int n = 1; n < STAGES; n++) sync_r[n] <= sync_r[n-1];
        end
    end

    assign sync_out = sync_r[STAGES-1];

    if (FILTER_CYC == 0) begin : g_no_filter
        assign o_level = sync_out;
    end else begin : g_filter
        localparam int              CNT_W    = $clog2(FILTER_CYC + 1);
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYC - 1);

        logic [CNT_W-1:0]    cnt_r [CHANNELS];
        logic [CHANNELS-1:0] f_r;

        // The count restarts whenever the synced value agrees with f, so only an
        // uninterrupted run of FILTER_CYC disagreeing cycles moves the level.
        always_ff @(posedge clk) begin
            if (rst) begin
                f_r <= RESET_VAL;
                for (int k = 0; k < CHANNELS; k++) cnt_r[k] <= '0;
            end else begin
                for (int k = 0; k < CHANNELS; k++) begin
                    if (sync_out[k] == f_r[k]) begin
                        cnt_r[k] <= '0;
                    end else if (cnt_r[k] == CNT_LAST) begin
                        f_r[k]   <= sync_out[k];
                        cnt_r[k] <= '0;
                    end else begin
                        cnt_r[k] <= cnt_r[k] + CNT_W'(1);
                    end
                end
            end
        end

        assign o_level = f_r;
    end

    always_ff @(posedge clk) begin
        if (rst) prev_r <= RESET_VAL;
        else     prev_r <= o_level;
    end

    assign rise = o_level & ~prev_r;
    assign fall = ~o_level & prev_r;

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        o_pulse = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            case (i_mode[2*k +: 2])
                2'b01:   o_pulse[k] = rise[k];
                2'b10:   o_pulse[k] = fall[k];
                2'b11:   o_pulse[k] = rise[k] | fall[k];
                default: o_pulse[k] = 1'b0;
            endcase
        end
    end

    // A new pulse beats a simultaneous clear so no event is ever lost.
    always_ff @(posedge clk) begin
        if (rst) event_r <= '0;
        else     event_r <= o_pulse | (event_r & ~i_clear);
    end

    assign o_event = event_r;

endmodule

// File: tb/tb_sync_array.sv
// Bench for sync_array: two instances (unfiltered STAGES=3, filtered STAGES=2/FILTER_CYC=4)
// compared every cycle against a sample-history reference model, plus directed checks.
module tb_sync_array;

    localparam int          NI   = 2;
    localparam int          S_A  = 3;
    localparam int          F_A  = 0;
    localparam logic [3:0]  RV_A = 4'b1010;
    localparam int          S_B  = 2;
    localparam int          F_B  = 4;
    localparam logic [3:0]  RV_B = 4'b0000;

    logic       clk;
    logic       rst;
    logic [3:0] ctrl [NI];
    logic [7:0] mode [NI];
    logic [3:0] clr  [NI];
    logic [3:0] lvl  [NI];
    logic [3:0] pls  [NI];
    logic [3:0] evt  [NI];

    int checks = 0;
    int errors = 0;

    sync_array #(.CHANNELS(4), .STAGES(S_A), .FILTER_CYC(F_A), .RESET_VAL(RV_A)) dut_a (
        .clk(clk), .rst(rst), .i_ctrl(ctrl[0]), .i_mode(mode[0]), .i_clear(clr[0]),
        .o_level(lvl[0]), .o_pulse(pls[0]), .o_event(evt[0])
    );

    sync_array #(.CHANNELS(4), .STAGES(S_B), .FILTER_CYC(F_B), .RESET_VAL(RV_B)) dut_b (
        .clk(clk), .rst(rst), .i_ctrl(ctrl[1]), .i_mode(mode[1]), .i_clear(clr[1]),
        .o_level(lvl[1]), .o_pulse(pls[1]), .o_event(evt[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: hist[i][n] is i_ctrl as sampled n edges ago, so the synced
    // value is the sample STAGES-1 entries back; m_run counts consecutive edges on
    // which the synced value disagreed with the filtered level.
    int         stg [NI];
    int         flt [NI];
    logic [3:0] rv  [NI];
    logic [3:0] hist [NI][8];
    logic [3:0] m_f    [NI];
    logic [3:0] m_prev [NI];
    logic [3:0] m_ev   [NI];
    int         m_run  [NI][4];

    function automatic logic [3:0] m_level(int i);
        if (flt[i] == 0) return hist[i][stg[i]-1];
        return m_f[i];
    endfunction

    function automatic logic [3:0] m_pulse(int i, logic [7:0] md);
        logic [3:0] lv, r, f, p;
        lv = m_level(i);
        r  = lv & ~m_prev[i];
        f  = ~lv & m_prev[i];
        p  = '0;
        for (int k = 0; k < 4; k++) begin
            case (md[2*k +: 2])
                2'b01:   p[k] = r[k];
                2'b10:   p[k] = f[k];
                2'b11:   p[k] = r[k] | f[k];
                default: p[k] = 1'b0;
            endcase
        end
        return p;
    endfunction

    task automatic model_reset(int i);
        for (int n = 0; n < 8; n++) hist[i][n] = rv[i];
        m_f[i]    = rv[i];
        m_prev[i] = rv[i];
        m_ev[i]   = '0;
        for (int k = 0; k < 4; k++) m_run[i][k] = 0;
    endtask

    task automatic model_edge(int i);
        logic [3:0] s, p;
        if (rst) begin
            model_reset(i);
        end else begin
            s         = hist[i][stg[i]-1];
            p         = m_pulse(i, mode[i]);
            m_ev[i]   = p | (m_ev[i] & ~clr[i]);
            m_prev[i] = m_level(i);
            if (flt[i] > 0) begin
                for (int k = 0; k < 4; k++) begin
                    if (s[k] != m_f[i][k]) begin
                        m_run[i][k]++;
                        if (m_run[i][k] == flt[i]) begin
                            m_f[i][k]    = s[k];
                            m_run[i][k]  = 0;
                        end
                    end else begin
                        m_run[i][k] = 0;
                    end
                end
            end
            for (int n = 7; n > 0; n--) hist[i][n] = hist[i][n-1];
            hist[i][0] = ctrl[i];
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: update the model at the edge, then compare every output 1ns later.
    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < NI; i++) model_edge(i);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("level%0d", i), lvl[i], m_level(i));
            chk($sformatf("pulse%0d", i), pls[i], m_pulse(i, mode[i]));
            chk($sformatf("event%0d", i), evt[i], m_ev[i]);
        end
    endtask

    task automatic step(int n);
        repeat (n) tick();
    endtask

    initial begin
        int npulse;
        stg = '{S_A, S_B};
        flt = '{F_A, F_B};
        rv  = '{RV_A, RV_B};
        for (int i = 0; i < NI; i++) begin
            model_reset(i);
            ctrl[i] = '0;
            clr[i]  = '0;
        end
        mode[0] = 8'b00_01_10_01;
        mode[1] = 8'b00_01_11_01;

        // Reset with inputs different from RESET_VAL on dut_a.
        rst = 1'b1;
        step(2);
        chk("a reset level", lvl[0], 4'b1010);
        chk("a reset pulse", pls[0], 4'b0000);
        chk("b reset level", lvl[1], 4'b0000);
        chk("a reset event", evt[0], 4'b0000);

        // Release: ch2 rises, ch1/ch3 fall after STAGES edges.
        rst     = 1'b0;
        ctrl[0] = 4'b0100;
        step(2);
        chk("a level before latency", lvl[0], 4'b1010);
        tick();
        chk("a level after STAGES", lvl[0], 4'b0100);
        chk("a pulse rise2 fall1", pls[0], 4'b0110);
        chk("a event not yet", evt[0], 4'b0000);
        tick();
        chk("a pulse one cycle", pls[0], 4'b0000);
        chk("a event set", evt[0], 4'b0110);
        step(3);
        chk("a event held", evt[0], 4'b0110);

        // Filtered channel: 3-cycle glitch is suppressed.
        ctrl[1][0] = 1'b1;
        step(3);
        ctrl[1][0] = 1'b0;
        step(10);
        chk("b glitch level", lvl[1][0], 1'b0);
        chk("b glitch event", evt[1][0], 1'b0);

        // Sustained high: level rises after edge STAGES+FILTER_CYC.
        ctrl[1][0] = 1'b1;
        step(5);
        chk("b level before filter", lvl[1][0], 1'b0);
        tick();
        chk("b level after filter", lvl[1][0], 1'b1);
        chk("b pulse after filter", pls[1][0], 1'b1);
        step(4);
        chk("b event after filter", evt[1][0], 1'b1);

        // Any-edge mode on ch1: two pulses; falling-only mode: one.
        npulse = 0;
        ctrl[1][1] = 1'b1;
        for (int c = 0; c < 8; c++) begin tick(); if (pls[1][1]) npulse++; end
        ctrl[1][1] = 1'b0;
        for (int c = 0; c < 8; c++) begin tick(); if (pls[1][1]) npulse++; end
        chk("b mode11 pulses", npulse, 2);
        mode[1][3:2] = 2'b10;
        npulse = 0;
        ctrl[1][1] = 1'b1;
        for (int c = 0; c < 8; c++) begin tick(); if (pls[1][1]) npulse++; end
        ctrl[1][1] = 1'b0;
        for (int c = 0; c < 8; c++) begin tick(); if (pls[1][1]) npulse++; end
        chk("b mode10 pulses", npulse, 1);

        // Set beats clear; clear alone drops the flag.
        mode[0][7:6] = 2'b11;
        ctrl[0][3]   = 1'b1;
        step(4);
        chk("a event3 set", evt[0][3], 1'b1);
        ctrl[0][3] = 1'b0;
        step(3);
        chk("a pulse3 fall", pls[0][3], 1'b1);
        clr[0][3] = 1'b1;
        tick();
        chk("a set wins clear", evt[0][3], 1'b1);
        tick();
        chk("a clear alone", evt[0][3], 1'b0);
        clr[0][3] = 1'b0;

        // Reset in the middle of a pending filter count.
        ctrl[1][2] = 1'b1;
        step(4);
        chk("b pending level", lvl[1][2], 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("b level in reset", lvl[1][2], 1'b0);
        step(5);
        chk("b relatency before", lvl[1][2], 1'b0);
        tick();
        chk("b relatency after", lvl[1][2], 1'b1);

        // Toggling every cycle never passes the filter.
        for (int c = 0; c < 20; c++) begin
            ctrl[1][3] = ~ctrl[1][3];
            tick();
        end
        chk("b toggle level", lvl[1][3], 1'b0);

        // Random phase, occasional reset.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NI; i++) begin
                for (int k = 0; k < 4; k++)
                    if ($urandom_range(5) == 0) ctrl[i][k] = ~ctrl[i][k];
                if ($urandom_range(7) == 0) mode[i] = 8'($urandom);
                clr[i] = 4'($urandom) & 4'($urandom);
            end
            rst = ($urandom_range(60) == 0);
            tick();
        end
        rst = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_array.md
Name: sync_array

Overview:
- Parametrised multi-channel control-signal synchroniser; successor to the single-bit 2-flop synchroniser.
- Brings CHANNELS asynchronous control bits into the clk domain.
- Synchroniser depth is configurable, with an optional per-channel stability (debounce) filter.
- Per-channel runtime edge-detect mode produces one-cycle pulses and sticky, clearable event flags for CSR/status use.

Parameters:
- CHANNELS, 8, number of independent control bits (>=1).
- STAGES, 2, synchroniser flop depth per channel (>=2; elaboration error otherwise).
- FILTER_CYC, 0, consecutive stable cycles required before the filtered level changes; 0 bypasses the filter.
- RESET_VAL, 0 (CHANNELS bits), reset value of the sync chain, filtered level and edge history, per channel.

Ports:
- clk  input  1  destination-domain clock.
- rst  input  1  reset, synchronous, active-high.
- i_ctrl  input  CHANNELS  asynchronous control inputs, one bit per channel.
- i_mode  input  2*CHANNELS  per-channel mode, bits [2k+1:2k] for channel k: 00 level-only, 01 rising, 10 falling, 11 any edge. Synchronous to clk.
- i_clear  input  CHANNELS  per-channel clear of o_event. Synchronous, level-sensitive.
- o_level  output  CHANNELS  synchronised, optionally filtered, level.
- o_pulse  output  CHANNELS  one-cycle pulse on the selected edge of o_level.
- o_event  output  CHANNELS  sticky flag, set by o_pulse, cleared by i_clear.

Behaviour:
- Per-channel logic is fully independent; no cross-channel state.
- Sync chain: sync_r[0] <= i_ctrl; sync_r[n] <= sync_r[n-1]; sync_out = sync_r[STAGES-1]. No logic is permitted between chain flops.

Filter, FILTER_CYC = 0:
- o_level = sync_out.
- Latency: an i_ctrl change sampled at edge 1 appears on o_level after edge STAGES.

Filter, FILTER_CYC > 0:
- Register f per channel; o_level = f. Counter cnt per channel, width clog2(FILTER_CYC+1).
- Each edge:
  - if sync_out == f: cnt <= 0;
  - else if cnt == FILTER_CYC-1: f <= sync_out, cnt <= 0;
  - else: cnt <= cnt+1.
- Latency: o_level changes after edge STAGES+FILTER_CYC.
- A synced excursion lasting fewer than FILTER_CYC cycles is fully suppressed: cnt returns to 0 and f is unchanged.

Edge detection:
- prev <= o_level each edge.
- o_pulse is combinational from registered state and the current i_mode:
  - rise = o_level & ~prev
  - fall = ~o_level & prev
  - 00 -> 0; 01 -> rise; 10 -> fall; 11 -> rise | fall.
- Each selected o_level transition yields exactly one cycle of o_pulse, in the cycle immediately after the transition edge.
- An i_mode change takes effect in the same cycle (combinational). It does not generate a pulse by itself.

Sticky event flag:
- o_event[k] <= o_pulse[k] ? 1 : (i_clear[k] ? 0 : o_event[k]).
- Set wins over a simultaneous clear.

Reset:
- sync_r all stages, f and prev <= RESET_VAL; cnt <= 0; o_event <= 0.
- Hence after reset o_level = RESET_VAL and o_pulse = 0. No spurious pulse on reset release, even if i_ctrl differs from RESET_VAL; that difference propagates as a normal transition.
- Reset asserted mid-filter count discards the pending count.

Boundary cases:
- i_ctrl toggling every cycle with FILTER_CYC >= 2: o_level never changes.
- cnt saturation is impossible: it resets at FILTER_CYC-1.
- CHANNELS = 1 is legal.

Test Plan:
- CHANNELS=4, STAGES=3, FILTER_CYC=0, RESET_VAL=0, mode=01 all. Drive i_ctrl[2] 0->1 before edge 1 -> o_level[2]=1 after edge 3; o_pulse[2]=1 for exactly one cycle after edge 3; o_event[2]=1 from edge 4 and held.
- FILTER_CYC=4, STAGES=2. 3-cycle high glitch on i_ctrl[0] -> o_level[0], o_pulse[0] and o_event[0] stay 0. Then hold high for 10 cycles -> o_level[0] rises after edge 6 relative to the first sample.
- Mode 11 on channel 1. Input goes 0->1, held 8 cycles, then 1->0 -> two o_pulse[1] single-cycle pulses. Mode 10 on channel 1 -> only the falling-edge pulse.
- RESET_VAL=4'b1010 with i_ctrl=4'b0000 through reset -> o_level=1010 and o_pulse=0 at release. After release, channels 1 and 3 fall after STAGES edges, pulsing only if mode is 10 or 11.
- o_event[3] set, then i_clear[3] asserted in the same cycle as a new o_pulse[3] -> o_event[3] stays 1. Clear alone -> 0 on the next edge.
- FILTER_CYC=4. Assert rst when cnt=2 on a pending change -> after release, cnt=0, o_level=RESET_VAL, and the full STAGES+FILTER_CYC latency is re-applied.
